// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and constants for the load/store sequencer:
//                FSM state encoding, access size encoding, lane selects and
//                small decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // Access size derived from the lb/lh decoder flags
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Byte lanes within a word (addr[1:0])
    localparam logic [1:0] c_lane_b0 = 2'd0;
    localparam logic [1:0] c_lane_b1 = 2'd1;
    localparam logic [1:0] c_lane_b2 = 2'd2;
    localparam logic [1:0] c_lane_b3 = 2'd3;

    // Half lanes within a word (addr[1])
    localparam logic c_half_lo = 1'b0;
    localparam logic c_half_hi = 1'b1;

    // lb wins over lh; neither flag means a full word
    function automatic size_e size_from_flags(input logic lb, input logic lh);
        if (lb) begin
            return SZ_BYTE;
        end else if (lh) begin
            return SZ_HALF;
        end
        return SZ_WORD;
    endfunction

    // True when the low address bits do not match the natural alignment
    function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
        return ((size == SZ_HALF) && lo[0]) ||
               ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane
//  Description : Combinational lane logic. Extracts a byte/half/word from a
//                memory word with sign or zero extension for loads, and
//                merges store data into the addressed lane for sub-word
//                read-modify-write stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,      // word returned by memory
    input  logic [1:0]  lane,       // byte address low bits
    input  size_e       size,       // access size
    input  logic        uns,        // zero-extend instead of sign-extend
    input  logic [31:0] sdata,      // store data (low byte/half for sub-word)
    output logic [31:0] load_data,  // extended load result
    output logic [31:0] merge_data  // word to write back for a store
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_bsign;
    logic        w_hsign;

    // Select the addressed byte and half from the memory word
    always_comb begin
        w_byte = rdata[7:0];
        case (lane)
            c_lane_b0: w_byte = rdata[7:0];
            c_lane_b1: w_byte = rdata[15:8];
            c_lane_b2: w_byte = rdata[23:16];
            c_lane_b3: w_byte = rdata[31:24];
            default:   w_byte = rdata[7:0];
        endcase
        w_half  = (lane[1] == c_half_hi) ? rdata[31:16] : rdata[15:0];
        w_bsign = w_byte[7] & ~uns;
        w_hsign = w_half[15] & ~uns;
    end

    // Extend the selected lane to a full word; word loads pass through
    always_comb begin
        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = {{24{w_bsign}}, w_byte};
            SZ_HALF: load_data = {{16{w_hsign}}, w_half};
            default: load_data = rdata;
        endcase
    end

    // Overlay the store byte/half onto the word read back from memory
    always_comb begin
        merge_data = rdata;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    c_lane_b0: merge_data[7:0]   = sdata[7:0];
                    c_lane_b1: merge_data[15:8]  = sdata[7:0];
                    c_lane_b2: merge_data[23:16] = sdata[7:0];
                    c_lane_b3: merge_data[31:24] = sdata[7:0];
                    default:   merge_data[7:0]   = sdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1] == c_half_hi) begin
                    merge_data[31:16] = sdata[15:0];
                end else begin
                    merge_data[15:0]  = sdata[15:0];
                end
            end
            default: merge_data = sdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_seq
//  Description : Load/store sequencer between the core and a word-only data
//                memory. One access per accepted start; word reads for loads,
//                read-modify-write for sub-word stores, extended load data
//                with a one-cycle done pulse.
//                Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half
//                or word accesses skip memory and pulse err together with
//                done. Without it the offending low address bits are ignored
//                and err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_seq
    import lsu_pkg::*;
#(
    parameter int AW = 32,   // byte-address width
    parameter int DW = 32    // data width, fixed at 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          lb,
    input  logic          lh,
    input  logic          lbu,
    input  logic          lhu,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam logic [1:0] c_st_idle = ST_IDLE;
    localparam logic [1:0] c_st_rd   = ST_RD;
    localparam logic [1:0] c_st_wr   = ST_WR;
    localparam logic [1:0] c_st_fin  = ST_FIN;

    logic [1:0]    r_state;
    logic          r_we;
    logic [1:0]    r_lane;
    logic [DW-1:0] r_wdata;
    size_e         r_size;
    logic          r_uns;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_done;

    size_e         w_start_size;
    logic          w_accept;
    logic          w_trap;
    logic          w_ack;
    logic [31:0]   w_load;
    logic [31:0]   w_merge;

    assign w_start_size = size_from_flags(lb, lh);
    assign w_accept     = start && (r_state == c_st_idle);
    // An ack only counts while a request is actually outstanding
    assign w_ack        = r_mem_req && mem_ack;

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_err;
    assign w_trap = is_misaligned(w_start_size, addr[1:0]);
    assign err    = r_err;
`else
    assign w_trap = 1'b0;
    assign err    = 1'b0;
`endif

    lsu_lane u_lane (
        .rdata      (mem_rdata),
        .lane       (r_lane),
        .size       (r_size),
        .uns        (r_uns),
        .sdata      (r_wdata),
        .load_data  (w_load),
        .merge_data (w_merge)
    );

    // Sequencer FSM together with the registered memory interface
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= c_st_idle;
            r_we        <= 1'b0;
            r_lane      <= 2'b00;
            r_wdata     <= '0;
            r_size      <= SZ_WORD;
            r_uns       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_done      <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_we    <= we;
                        r_lane  <= addr[1:0];
                        r_wdata <= wdata;
                        r_size  <= w_start_size;
                        r_uns   <= lbu | lhu;
                        if (w_trap) begin
                            // Misaligned access: straight to completion
                            r_state <= c_st_fin;
                            r_done  <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                            r_err   <= 1'b1;
`endif
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {addr[AW-1:2], 2'b00};
                            if (we && (w_start_size == SZ_WORD)) begin
                                r_state     <= c_st_wr;
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= wdata;
                            end else begin
                                // Loads and the read half of sub-word stores
                                r_state  <= c_st_rd;
                                r_mem_we <= 1'b0;
                            end
                        end
                    end
                end
                c_st_rd: begin
                    if (w_ack) begin
                        r_mem_req <= 1'b0;
                        if (r_we) begin
                            // Write request is raised one cycle later
                            r_mem_wdata <= w_merge;
                            r_state     <= c_st_wr;
                        end else begin
                            r_rdata <= w_load;
                            r_state <= c_st_fin;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_st_wr: begin
                    if (!r_mem_req) begin
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b1;
                    end else if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= c_st_fin;
                        r_done    <= 1'b1;
                    end
                end
                c_st_fin: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy      = (r_state != c_st_idle);
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_seq
//  Description : Self-checking bench for lsu_seq. Table of accesses against a
//                single-word memory model with programmable wait states,
//                scoreboard of expected load results, and hand-written
//                sequences for ignored starts and reset mid-access.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_seq;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lb, lh, lbu, lhu;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack   = 1'b0;

    always #5 clk = ~clk;

    lsu_seq #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .lb        (lb),
        .lh        (lh),
        .lbu       (lbu),
        .lhu       (lhu),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // Memory model configuration (written only by the stimulus process)
    logic [31:0] cfg_word;
    int          cfg_waits;
    bit          cfg_hold;
    bit          cfg_force;

    // Memory model state and observation counters
    int          wcnt     = 0;
    int          rd_cnt   = 0;
    int          wr_cnt   = 0;
    int          req_cnt  = 0;
    int          done_cnt = 0;
    bit          prev_req = 1'b0;
    logic [31:0] rd_addr  = 32'h0;
    logic [31:0] wr_addr  = 32'h0;
    logic [31:0] wr_data  = 32'h0;

    // Word memory responding on the falling edge with programmable waits
    always @(negedge clk) begin
        if (mem_req && !prev_req) req_cnt++;
        prev_req = mem_req;
        if (done) done_cnt++;
        if (cfg_force) begin
            mem_ack = 1'b1;
        end else if (mem_req && !cfg_hold) begin
            if (wcnt == cfg_waits) begin
                mem_ack = 1'b1;
                wcnt    = 0;
                if (mem_we) begin
                    wr_cnt++;
                    wr_addr = mem_addr;
                    wr_data = mem_wdata;
                end else begin
                    rd_cnt++;
                    rd_addr = mem_addr;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
        mem_rdata = mem_ack ? cfg_word : 32'hDEAD_0000;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  fl;        // {lb, lh, lbu, lhu}
        logic [31:0] mword;
        int          waits;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cyc;
        int          exp_rd;
        logic [31:0] exp_rd_addr;
        int          exp_wr;
        logic [31:0] exp_wr_addr;
        logic [31:0] exp_wr_data;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    localparam logic [3:0] F_LB  = 4'b1000;
    localparam logic [3:0] F_LBU = 4'b1010;
    localparam logic [3:0] F_LH  = 4'b0100;
    localparam logic [3:0] F_LHU = 4'b0101;
    localparam logic [3:0] F_W   = 4'b0000;

    vec_t vt[$];
    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic w, logic [31:0] a, logic [31:0] wd, logic [3:0] fl,
                                logic [31:0] mw, int wt, logic [31:0] er, logic ee, int ec,
                                int nr, logic [31:0] ra, int nw, logic [31:0] wa,
                                logic [31:0] wdd);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = wd; v.fl = fl; v.mword = mw; v.waits = wt;
        v.exp_rdata = er; v.exp_err = ee; v.exp_cyc = ec;
        v.exp_rd = nr; v.exp_rd_addr = ra; v.exp_wr = nw; v.exp_wr_addr = wa;
        v.exp_wr_data = wdd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        start = 1'b1;
        we    = v.we;
        addr  = v.addr;
        wdata = v.wdata;
        {lb, lh, lbu, lhu} = v.fl;
    endtask

    // Wait for done starting at cycle 'cyc'; returns the done cycle or -1
    task automatic wait_done(input int cyc_in, output int cyc_out);
        int cyc;
        cyc     = cyc_in;
        cyc_out = -1;
        while (cyc <= 40) begin
            if (done) begin
                cyc_out = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_done(input string nm);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({nm, " scoreboard"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({nm, " rdata"}, rdata, e.rdata);
            chk({nm, " err"}, {31'd0, err}, {31'd0, e.err});
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   rd0, wr0, dc;
        exp_t e;
        string nm;
        nm = $sformatf("v%0d", idx);
        @(negedge clk);
        cfg_word  = v.mword;
        cfg_waits = v.waits;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        chk({nm, " idle busy"}, {31'd0, busy}, 32'd0);
        drive(v);
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk({nm, " busy"}, {31'd0, busy}, 32'd1);
        wait_done(1, dc);
        if (dc < 0) begin
            chk({nm, " done timeout"}, 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end else begin
            chk({nm, " done cycle"}, dc, v.exp_cyc);
            check_done(nm);
            chk({nm, " reads"}, rd_cnt - rd0, v.exp_rd);
            chk({nm, " writes"}, wr_cnt - wr0, v.exp_wr);
            if (v.exp_rd > 0) chk({nm, " read addr"}, rd_addr, v.exp_rd_addr);
            if (v.exp_wr > 0) begin
                chk({nm, " write addr"}, wr_addr, v.exp_wr_addr);
                chk({nm, " write data"}, wr_data, v.exp_wr_data);
            end
        end
    endtask

    initial begin
        int   r0, w0, q0, d0, dc;
        vec_t v;
        exp_t e;

        reset_n = 1'b0; start = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        lb = 1'b0; lh = 1'b0; lbu = 1'b0; lhu = 1'b0;
        cfg_word = '0; cfg_waits = 0; cfg_hold = 1'b0; cfg_force = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset busy",      {31'd0, busy},    32'd0);
        chk("reset done",      {31'd0, done},    32'd0);
        chk("reset err",       {31'd0, err},     32'd0);
        chk("reset mem_req",   {31'd0, mem_req}, 32'd0);
        chk("reset mem_we",    {31'd0, mem_we},  32'd0);
        chk("reset mem_addr",  mem_addr,  32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset rdata",     rdata,     32'd0);
        reset_n = 1'b1;

        //      we addr     wdata         flags  mem word      wt rdata                      err   cyc          rd           raddr   wr           waddr    wdata
        vt.push_back(mk(0, 'h103, 'h0,         F_LB,  'h80AABBCC, 0, 'hFFFFFF80,               0,    2,           1,           'h100,  0,           'h0,     'h0));
        vt.push_back(mk(0, 'h202, 'h0,         F_LHU, 'h92345678, 3, 'h00009234,               0,    5,           1,           'h200,  0,           'h0,     'h0));
        vt.push_back(mk(1, 'h301, 'h55,        F_LB,  'h11223344, 0, 'h00009234,               0,    4,           1,           'h300,  1,           'h300,   'h11225544));
        vt.push_back(mk(0, 'h040, 'h0,         F_W,   'h12345678, 0, 'h12345678,               0,    2,           1,           'h40,   0,           'h0,     'h0));
        vt.push_back(mk(0, 'h102, 'h0,         F_LBU, 'h80AABBCC, 1, 'h000000AA,               0,    3,           1,           'h100,  0,           'h0,     'h0));
        vt.push_back(mk(0, 'h200, 'h0,         F_LH,  'h9234F678, 0, 'hFFFFF678,               0,    2,           1,           'h200,  0,           'h0,     'h0));
        vt.push_back(mk(1, 'h502, 'hAAAABEEF,  F_LH,  'h11223344, 1, 'hFFFFF678,               0,    6,           1,           'h500,  1,           'h500,   'hBEEF3344));
        vt.push_back(mk(1, 'h040, 'hDEADBEEF,  F_W,   'h0,        0, 'hFFFFF678,               0,    2,           0,           'h0,    1,           'h40,    'hDEADBEEF));
        vt.push_back(mk(0, 'h100, 'h0,         F_LB,  'h0000007F, 0, 'h0000007F,               0,    2,           1,           'h100,  0,           'h0,     'h0));
        vt.push_back(mk(0, 'h011, 'h0,         F_LH,  'hCAFE8001, 0, TRAP ? 'h7F : 'hFFFF8001, TRAP, TRAP ? 1 : 2, TRAP ? 0 : 1, 'h10,   0,           'h0,     'h0));
        vt.push_back(mk(1, 'h043, 'h01020304,  F_W,   'h0,        0, TRAP ? 'h7F : 'hFFFF8001, TRAP, TRAP ? 1 : 2, 0,            'h0,    TRAP ? 0 : 1, 'h40,   'h01020304));
        vt.push_back(mk(1, 'h603, 'h000001FF,  F_LB,  'h11223344, 2, TRAP ? 'h7F : 'hFFFF8001, 0,    8,           1,           'h600,  1,           'h600,   'hFF223344));
        vt.push_back(mk(0, 'h202, 'h0,         F_LH,  'h80010000, 0, 'hFFFF8001,               0,    2,           1,           'h200,  0,           'h0,     'h0));
        vt.push_back(mk(0, 'h046, 'h0,         F_W,   'hA5A55A5A, 0, TRAP ? 'hFFFF8001 : 'hA5A55A5A, TRAP, TRAP ? 1 : 2, TRAP ? 0 : 1, 'h44, 0,      'h0,     'h0));

        foreach (vt[i]) run_vec(vt[i], i);

        // Word store with a second start while busy: one request, one done
        @(negedge clk);
        cfg_word = '0; cfg_waits = 2;
        r0 = rd_cnt; w0 = wr_cnt; q0 = req_cnt; d0 = done_cnt;
        v = mk(1, 'h40, 'hDEADBEEF, F_W, 'h0, 2, 'h0, 0, 0, 0, 'h0, 0, 'h0, 'h0);
        drive(v);
        e.rdata = TRAP ? 32'hFFFF8001 : 32'hA5A55A5A;
        e.err   = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        v = mk(0, 'h80, 'h0, F_LB, 'h0, 0, 'h0, 0, 0, 0, 'h0, 0, 'h0, 'h0);
        drive(v);
        @(negedge clk);
        start = 1'b0;
        wait_done(2, dc);
        if (dc < 0) begin
            chk("busy-start done timeout", 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end else begin
            chk("busy-start done cycle", dc, 32'd4);
            check_done("busy-start");
        end
        repeat (5) @(negedge clk);
        chk("busy-start requests", req_cnt - q0, 32'd1);
        chk("busy-start writes",   wr_cnt - w0,  32'd1);
        chk("busy-start reads",    rd_cnt - r0,  32'd0);
        chk("busy-start dones",    done_cnt - d0, 32'd1);
        chk("busy-start wdata",    wr_data, 32'hDEADBEEF);
        chk("busy-start waddr",    wr_addr, 32'h40);

        // Reset while a read is outstanding and ack is withheld
        @(negedge clk);
        cfg_hold = 1'b1;
        cfg_waits = 0;
        d0 = done_cnt;
        v = mk(0, 'h100, 'h0, F_LB, 'h0, 0, 'h0, 0, 0, 0, 'h0, 0, 'h0, 'h0);
        drive(v);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("midreset req before", {31'd0, mem_req}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midreset mem_req", {31'd0, mem_req}, 32'd0);
        chk("midreset busy",    {31'd0, busy},    32'd0);
        chk("midreset done",    {31'd0, done},    32'd0);
        reset_n  = 1'b1;
        cfg_hold = 1'b0;
        cfg_force = 1'b1;
        repeat (2) @(negedge clk);
        cfg_force = 1'b0;
        repeat (4) @(negedge clk);
        chk("stray-ack dones",     done_cnt - d0, 32'd0);
        chk("stray-ack busy",      {31'd0, busy},    32'd0);
        chk("stray-ack mem_req",   {31'd0, mem_req}, 32'd0);
        chk("stray-ack mem_we",    {31'd0, mem_we},  32'd0);
        chk("stray-ack err",       {31'd0, err},     32'd0);
        chk("stray-ack rdata",     rdata,     32'd0);
        chk("stray-ack mem_addr",  mem_addr,  32'd0);
        chk("stray-ack mem_wdata", mem_wdata, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_seq.md
# lsu_seq

Load/store sequencer between the riscv32i core and a word-only data memory. Accepts one access per start pulse, using the size/sign flags from the ALU decoder (lb/lh/lbu/lhu). Performs word reads for loads and a read-modify-write for sub-word stores. Returns sign- or zero-extended load data with a one-cycle done pulse. The core stalls on busy.

## Interface
- Parameters
  - AW, 32, byte-address width.
  - DW, 32, data width; fixed at 32.
- Ports
  - clk  in  1  rising-edge clock.
  - reset_n  in  1  synchronous, active-low reset.
  - start  in  1  access request; accepted only while busy=0.
  - we  in  1  1=store, 0=load.
  - addr  in  AW  byte address.
  - wdata  in  32  store data; the low byte or half is used for sub-word stores.
  - lb, lh, lbu, lhu  in  1 each  size/sign flags. lbu implies lb and lhu implies lh. Neither lb nor lh means a word access.
  - busy  out  1  high from the cycle after acceptance until done.
  - done  out  1  one-cycle completion pulse.
  - rdata  out  32  extended load data; valid at done and held until the next accepted start.
  - err  out  1  one-cycle misalignment pulse (see Configuration).
  - mem_req  out  1  memory request; held until ack.
  - mem_we  out  1  memory write strobe.
  - mem_addr  out  AW  word address, bits [1:0]=0.
  - mem_wdata  out  32  full word to write.
  - mem_rdata  in  32  read data; valid with mem_ack.
  - mem_ack  in  1  completes the current request; ignored while mem_req=0.

## Operation
- States:
  - IDLE.
  - RD: read request outstanding.
  - WR: write request outstanding.
  - FIN: drive done.
- On start in IDLE, latch we, addr, wdata and the size flags.
- IDLE transitions on accepted start:
  - Load → RD.
  - Word store → WR; mem_wdata = wdata.
  - Sub-word store → RD.
- RD on mem_ack:
  - Load: capture the extracted/extended lane into rdata → FIN.
  - Sub-word store: merge the latched byte/half into mem_rdata at lane addr[1:0] (half uses lane addr[1]) → WR.
- WR on mem_ack → FIN.
- FIN: done=1 → IDLE.
- Load extension:
  - lb selects byte addr[1:0] and sign-extends bit 7.
  - lbu zero-extends the byte.
  - lh/lhu select half addr[1], sign- or zero-extended from bit 15.
  - A word load passes mem_rdata through unchanged.
- Start while busy is ignored and not queued. Flags are only sampled at acceptance.
- Reset values: state IDLE; busy=0, done=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0.
- Reset asserted mid-access:
  - Returns to IDLE at that edge and drops mem_req.
  - No done is produced.
  - A later ack for the abandoned request is ignored.

## Timing
- mem_req, mem_we, mem_addr and mem_wdata are registered. They rise the cycle after the state is entered and stay stable until the ack cycle.
- After the ack edge, mem_req deasserts for at least one cycle before the next request (RD→WR has a one-cycle gap).
- Zero-wait memory (ack in the first req cycle):
  - Load or word store: start at cycle 0, req in cycle 1, done in cycle 2.
  - Sub-word store: read in cycle 1, write in cycle 3, done in cycle 4.
- Each wait state on ack adds one cycle.
- start may be accepted in the cycle after done (back-to-back throughput is one access per latency+1 cycles).

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A half access with addr[0]=1 or a word access with addr[1:0]≠0 performs no memory access.
  - err pulses in the cycle after start (via FIN, so done also pulses).
  - rdata is unchanged.
- Undefined:
  - Offending low address bits are ignored (half uses addr[1], word forces lane 0).
  - err is tied 0.

## Structure
- Shared package lsu_pkg:
  - State enum (IDLE, RD, WR, FIN).
  - 2-bit size encoding (BYTE, HALF, WORD) derived from lb/lh.
  - Lane-select constants.
- Sub-module lsu_lane: combinational lane extraction with sign/zero extension for loads, plus the byte/half merge for stores.
- The FSM and registers stay in lsu_seq.

## Test plan
- Load byte, signed: lb=1, addr=0x103, mem_rdata=0x80AA_BBCC, zero-wait → rdata=0xFFFF_FF80, done at cycle 2, single mem_req with mem_addr=0x100.
- Load half, unsigned: lhu=lh=1, addr=0x202, mem_rdata=0x9234_5678, ack after 3 wait cycles → rdata=0x0000_9234, done 3 cycles later than the zero-wait case.
- Store byte: we=1, lb=1, addr=0x301, wdata=0x55, memory word 0x1122_3344 → read then write of 0x1122_5544 to 0x300, done at cycle 4.
- Word store plus ignored start: store 0xDEAD_BEEF to 0x40; a second start while busy=1 causes no extra mem_req; the single write produces one done.
- Reset mid-access: assert reset_n=0 while in RD with ack withheld → next cycle mem_req=0, busy=0, no done; a stray ack afterwards leaves outputs at their reset values.
- Misalignment: lh at addr=0x11.
  - With LSU_MISALIGN_TRAP_EN: err=1 and done=1 at cycle 1, and mem_req never rises.
  - Without it: a read at 0x10 returns half addr[1]=0.
